// File: rtl/mem_access_ctrl.sv
// Load/store controller: turns MIPS load/store requests into Avalon-MM word accesses,
// with read-modify-write for byte/halfword stores, alignment checks and a wait timeout.
module mem_access_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // Wide enough to hold MAX_WAIT itself.
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 2);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state;
  logic [5:0]         op_q;
  logic [1:0]         ofs_q;
  logic [15:0]        wdata_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               op_valid;
  logic               misaligned;
  logic               is_sub;
  logic [31:0]        merged;
  logic [CNT_W-1:0]   wait_nxt;
  logic               wait_expired;

  // Opcode legality and alignment of the incoming request.
  always_comb begin
    op_valid   = 1'b0;
    misaligned = 1'b0;
    case (op)
      OP_LB, OP_LBU, OP_SB, OP_LWL, OP_LWR: op_valid = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        op_valid   = 1'b1;
        misaligned = addr[0];
      end
      OP_LW, OP_SW: begin
        op_valid   = 1'b1;
        misaligned = (addr[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  // Big-endian byte/halfword insertion into the word just read.
  always_comb begin
    is_sub = (op_q == OP_SB) || (op_q == OP_SH);
    merged = mem_readdata;
    if (op_q == OP_SB) begin
      case (ofs_q)
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (op_q == OP_SH) begin
      if (ofs_q[1]) merged[15:0]  = wdata_q;
      else          merged[31:16] = wdata_q;
    end
  end

  // The access aborts on the wait cycle that brings the count up to MAX_WAIT.
  always_comb begin
    wait_nxt     = wait_cnt + CNT_W'(1);
    wait_expired = (wait_nxt >= CNT_W'(MAX_WAIT));
  end

  assign stall = !reset && ((state == RD) || (state == WR) ||
                            ((state == IDLE) && req && op_valid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= '0;
      ofs_q         <= '0;
      wdata_q       <= '0;
      wait_cnt      <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      mem_address   <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req && op_valid) begin
            op_q        <= op;
            ofs_q       <= addr[1:0];
            wdata_q     <= wdata[15:0];
            mem_address <= {addr[31:2], 2'b00};
            wait_cnt    <= '0;
            if (misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (op == OP_SW) begin
              state         <= WR;
              mem_write     <= 1'b1;
              mem_writedata <= wdata;
            end else begin
              state    <= RD;
              mem_read <= 1'b1;
            end
          end
        end
        RD: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            rdata    <= mem_readdata;
            if (is_sub) begin
              state         <= WR;
              mem_write     <= 1'b1;
              mem_writedata <= merged;
              wait_cnt      <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_expired) begin
              mem_read <= 1'b0;
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b1;
            end
          end
        end
        WR: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_expired) begin
              mem_write <= 1'b0;
              state     <= DONE;
              done      <= 1'b1;
              err       <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: the most consecutive mem_waitrequest-high cycles allowed in one bus access before the access is aborted.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  1  the pipeline requests a memory operation this cycle.
REQ-005 SHALL have port op  input  6  MIPS primary opcode: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011.
REQ-006 SHALL have port addr  input  32  effective byte address.
REQ-007 SHALL have port wdata  input  32  store operand; SB uses [7:0], SH uses [15:0].
REQ-008 SHALL have port stall  output  1  freezes the pipeline while an operation is in flight.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  one-cycle pulse, coincident with done, on misalignment or timeout.
REQ-011 SHALL have port rdata  output  32  last word read from memory, held until the next read completes.
REQ-012 SHALL have ports mem_address (output, 32), mem_read (output, 1), mem_write (output, 1), mem_writedata (output, 32), mem_readdata (input, 32) and mem_waitrequest (input, 1), forming an Avalon-MM style master.

Function
REQ-013 SHALL implement the states IDLE, RD, WR and DONE.
REQ-014 SHALL ignore req in IDLE when op is not listed in REQ-005; in that case it stays in IDLE and keeps stall low.
REQ-015 SHALL, on accepting a request in IDLE, register op, addr and wdata, and drive mem_address to {addr[31:2],2'b00} for the whole operation.
REQ-016 SHALL treat these as misaligned: LW, SW or LWL/LWR-free word ops with addr[1:0]!=0, and LH, LHU or SH with addr[0]=1. LB, LBU, SB, LWL and LWR are never misaligned.
REQ-017 SHALL, for a misaligned request, go IDLE->DONE with err=1 and make no bus access.
REQ-018 SHALL, for an aligned request, go IDLE->RD for any load, SB or SH, and go IDLE->WR for SW.
REQ-019 SHALL hold mem_read=1 in RD, with address stable, until a cycle in which mem_waitrequest=0.
REQ-020 SHALL, in that RD cycle, capture mem_readdata into rdata and then go to DONE for a load, or to WR for SB/SH.
REQ-021 SHALL build the WR data big-endian from the captured word:
- SB at offset k: replace bits [31-8k:24-8k] with wdata[7:0].
- SH at offset 0: replace [31:16] with wdata[15:0].
- SH at offset 2: replace [15:0] with wdata[15:0].
- SW: use wdata unchanged.
REQ-022 SHALL hold mem_write=1 and mem_writedata stable in WR until a cycle in which mem_waitrequest=0, then go to DONE.
REQ-023 SHALL never assert mem_read and mem_write in the same cycle.
REQ-024 SHALL run a wait counter that clears on entry to RD or WR and increments on each cycle with mem_waitrequest=1. When the counter equals MAX_WAIT, the controller drops the strobe and goes to DONE with err=1; rdata is not updated and no write is issued.
REQ-025 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; a request in the DONE cycle is not accepted.
REQ-026 SHALL drive stall combinationally as (state is RD or WR) OR (state is IDLE AND req AND op is valid), and hold stall=0 in DONE.
REQ-027 SHALL meet these zero-wait latencies, measured from the acceptance edge to the done cycle: load 2 cycles; SW 2 cycles; SB/SH 3 cycles; misaligned 1 cycle.

Reset
REQ-028 SHALL on reset assertion immediately force state=IDLE, with stall, done, err, mem_read and mem_write all 0, and rdata, mem_address, mem_writedata and the wait counter all 0.
REQ-029 SHALL, if reset arrives mid-operation, abandon the access with no completion pulse and no partial write, and accept a new request on the first edge after reset deasserts.

Verification
REQ-030 SHALL cover LW: addr=0x100, mem_readdata=0xDEADBEEF, no waits -> mem_address=0x100, rdata=0xDEADBEEF, done two cycles after acceptance, err=0.
REQ-031 SHALL cover SB: addr=0x203, wdata=0xAB, memory word 0x11223344 -> a read, then a write of 0x112233AB to 0x200, done at cycle 3.
REQ-032 SHALL cover SH: addr=0x202, wdata=0xCAFE, 3 wait cycles on the read -> read held for 4 cycles, write of 0x1122CAFE, stall high throughout.
REQ-033 SHALL cover misaligned accesses: LW at addr=0x101 -> no mem_read, done and err pulse one cycle after acceptance; same for SH at 0x203.
REQ-034 SHALL cover timeout: MAX_WAIT=4 with mem_waitrequest stuck high on LW -> mem_read drops after 4 wait cycles, done=err=1, rdata unchanged.
REQ-035 SHALL cover reset during WR of an SB -> mem_write falls in the same cycle, no done pulse, and the next LW completes normally.
